// File: rtl/seq_adder_n.sv
// seq_adder_n: multi-cycle signed adder/subtractor.
// Operands are captured once, then added CHUNK bits per clock (LSB slice
// first) through a single CHUNK-wide adder with a registered carry.
// Handshake: in_valid/in_ready on the request side, out_valid/out_ready on
// the result side.
// Optional feature: define SEQ_ADDER_FLAGS_EN to get registered carry and
// zero flags. Without it both outputs are tied to 0 and their logic is absent.
module seq_adder_n #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             overflow,
    output logic             carry,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Captured operands; b_reg already holds ~b for subtraction.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             cin_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             overflow_reg;

    logic             accept;
    logic             step;
    logic             last_slice;

    // Slice view of the operand registers, indexed by the chunk counter.
    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;
    logic             slice_ovf;

    assign accept     = (state_reg == ST_IDLE) && in_valid;
    assign step       = (state_reg == ST_RUN);
    assign last_slice = step && (idx_reg == LAST_IDX);

    // Split operands into chunks and merge the new slice into the sum image.
    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunk
            assign a_chunks[gi] = a_reg[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_reg[gi*CHUNK +: CHUNK];
            assign sum_next[gi*CHUNK +: CHUNK] =
                (idx_reg == IDX_W'(gi)) ? slice_sum : sum_reg[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_slice = a_chunks[idx_reg];
    assign b_slice = b_chunks[idx_reg];

    // One CHUNK-wide adder shared by every slice.
    assign {slice_cout, slice_sum} = {1'b0, a_slice} + {1'b0, b_slice}
                                   + {{CHUNK{1'b0}}, cin_reg};

    // Carry into the slice MSB recovered from the MSB sum bit; only the
    // final slice's value is used, where it is the carry into the word MSB.
    assign slice_cmsb = slice_sum[CHUNK-1] ^ a_slice[CHUNK-1] ^ b_slice[CHUNK-1];
    assign slice_ovf  = slice_cmsb ^ slice_cout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after last slice,
    // DONE -> IDLE on result handshake. in_valid is ignored outside IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)   state_next = ST_RUN;
            ST_RUN:  if (last_slice) state_next = ST_DONE;
            ST_DONE: if (out_ready)  state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, then one slice per RUN cycle. Nothing
    // changes in DONE, which keeps the result stable while back-pressured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            sum_reg      <= '0;
            cin_reg      <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= sub ? ~b : b;
            cin_reg <= sub;
            idx_reg <= '0;
        end else if (step) begin
            sum_reg <= sum_next;
            cin_reg <= slice_cout;
            idx_reg <= idx_reg + 1'b1;
            if (last_slice) begin
                overflow_reg <= slice_ovf;
            end
        end
    end

`ifdef SEQ_ADDER_FLAGS_EN
    logic carry_reg;
    logic zero_reg;

    // Unsigned carry-out and zero flag, latched on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
        end else if (last_slice) begin
            carry_reg <= slice_cout;
            zero_reg  <= (sum_next == '0);
        end
    end

    assign carry = carry_reg;
    assign zero  = zero_reg;
`else
    assign carry = 1'b0;
    assign zero  = 1'b0;
`endif

    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign sum       = sum_reg;
    assign overflow  = overflow_reg;

endmodule

// File: doc/seq_adder_n.md
SEQ_ADDER_N -- requirements
Module: seq_adder_n

Interface
REQ-001 SHALL have parameter WIDTH, default 64, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 16, bits added per cycle; WIDTH must be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, rising-edge active.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  operand request valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have ports a, b  input  WIDTH  signed two's-complement operands.
REQ-008 SHALL have port sub  input  1  0 = a+b, 1 = a-b.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port overflow  output  1  signed overflow.
REQ-013 SHALL have ports carry, zero  output  1 each  unsigned carry-out, result==0.

Function
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 in_ready SHALL be 1 only in IDLE; operands, sub captured on in_valid && in_ready, state -> RUN, chunk index = 0.
REQ-016 On capture, operand B register SHALL hold ~b and carry register = 1 when sub=1; b and carry = 0 when sub=0.
REQ-017 In RUN, each cycle SHALL add one CHUNK slice (LSB first) plus stored carry, write slice into sum register, update carry, increment index.
REQ-018 After slice NCHUNK-1 the FSM SHALL enter DONE; latency from accept to out_valid = NCHUNK+1 cycles (5 at defaults).
REQ-019 overflow SHALL equal carry into MSB XOR carry out of MSB of the final slice.
REQ-020 carry SHALL equal carry out of MSB (for sub: 1 means no borrow).
REQ-021 out_valid SHALL be 1 only in DONE; sum and flags SHALL stay stable while out_valid && !out_ready.
REQ-022 On out_valid && out_ready the FSM SHALL return to IDLE; a new request is accepted no earlier than the following cycle.
REQ-023 in_valid during RUN or DONE SHALL be ignored and not disturb the operation.
REQ-024 Operand inputs SHALL be ignored outside the accept cycle.
REQ-025 Results SHALL wrap modulo 2^WIDTH.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, overflow=0, carry=0, zero=0, index=0.
REQ-027 Reset during RUN or DONE SHALL abort the operation with no result emitted.
REQ-028 After rst_n deasserts, the first rising clk edge SHALL be able to accept a request.

Configuration
REQ-029 Macro SEQ_ADDER_FLAGS_EN: when defined, carry and zero SHALL be registered and updated per REQ-020 and REQ-013 at entry to DONE.
REQ-030 When SEQ_ADDER_FLAGS_EN is undefined, carry and zero SHALL be constant 0 and their logic omitted; sum, overflow and timing SHALL be unchanged.

Verification (WIDTH=64, CHUNK=16, SEQ_ADDER_FLAGS_EN defined)
REQ-031 a=5, b=7, sub=0, out_ready=1 -> out_valid exactly 5 cycles after accept, sum=12, overflow=0, carry=0, zero=0.
REQ-032 a=0x7FFFFFFFFFFFFFFF, b=1, sub=0 -> sum=0x8000000000000000, overflow=1, carry=0.
REQ-033 a=3, b=3, sub=1 -> sum=0, zero=1, carry=1, overflow=0; a=0, b=1, sub=1 -> sum=all ones, carry=0.
REQ-034 a=0xFFFF, b=1 (carry across chunk boundary) -> sum=0x10000; hold out_ready=0 for 3 cycles -> sum and flags stable, in_ready=0, new in_valid ignored.
REQ-035 Assert rst_n=0 in the 2nd RUN cycle -> out_valid=0 and in_ready=1 immediately, no result ever emitted; next request a=1, b=2 -> sum=3.
REQ-036 Rebuild without SEQ_ADDER_FLAGS_EN and rerun REQ-033 -> identical sum/overflow/timing, carry=0, zero=0.
